traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Receive-side checker for the 3-bit one-hot light bus {R,Y,G} driven by the traffic light controller.
//  - Samples the bus every clock and tracks the current colour.
//  - Checks legal order RED->GREEN->YELLOW->RED and exact dwell time per phase.
//  - Reports errors and counts completed cycles. Used in-system as a safety watchdog and as a bench scoreboard.
// PARAMETERS
//  RED_CYCLES     5   required consecutive cycles of RED (3'b100)
//  GREEN_CYCLES   5   required consecutive cycles of GREEN (3'b001)
//  YELLOW_CYCLES  3   required consecutive cycles of YELLOW (3'b010)
//  ERR_CNT_W      8   width of saturating error counter
//  CYC_CNT_W      16  width of wrapping cycle counter
// PORTS
//  clk          in   1          rising-edge clock
//  reset_n      in   1          asynchronous, active-low reset
//  light        in   3          observed light bus: R=bit2, Y=bit1, G=bit0
//  err_clr      in   1          clears err_code and err_count (sync, 1-cycle pulse)
//  phase        out  2          tracked phase: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW
//  err_pulse    out  1          one-cycle strobe per detected error
//  err_code     out  3          last error: 0 none, 1 ENC, 2 SEQ, 3 SHORT, 4 LONG; sticky
//  err_count    out  ERR_CNT_W  errors seen; saturates at all-ones
//  cycle_done   out  1          one-cycle strobe per fully checked R-G-Y-R cycle
//  cycle_count  out  CYC_CNT_W  number of cycle_done strobes; wraps modulo 2^CYC_CNT_W
// BEHAVIOUR
//  Reset: phase=SYNC, dwell=0, light_q=0. All other outputs are 0.
//  Input path: light is registered into light_q. All checks use light_q.
//  Latency: err_pulse and cycle_done rise 2 clk edges after the offending or completing value appears on light.
//  dwell: counts consecutive light_q samples equal to the phase colour. Width is $clog2(max(*_CYCLES)+2).
//  SYNC state:
//   - Watches for the first legal colour change, e.g. RED->GREEN. It then enters the new phase with dwell=1.
//   - Durations are unknown in SYNC, so no SHORT or LONG checks are made.
//   - Non-one-hot samples in SYNC do flag ENC.
//  RED / GREEN / YELLOW states. Priority per sample, highest first:
//   1 ENC: light_q not in {100,010,001}. Flag the error and go to SYNC.
//   2 SEQ: light_q is a one-hot colour other than the current or the next legal one. Flag and go to SYNC.
//   3 SHORT: light_q is the next legal colour but dwell < *_CYCLES.
//     Flag the error and still enter the next phase with dwell=1 (resynchronise).
//   4 LONG: light_q equals the current colour and dwell == *_CYCLES already. Flag once and go to SYNC.
//   5 Otherwise: on a legal change with exact dwell, advance phase and set dwell=1. Else increment dwell.
//  cycle_done:
//   - Pulses on a legal YELLOW->RED change with exact YELLOW dwell.
//   - Requires that the preceding GREEN->YELLOW change also had exact dwell, tracked by a clean flag.
//   - The clean flag is set on entering GREEN from an exact RED, or from SYNC. It is cleared on any error.
//   - The first cycle after SYNC therefore counts only if its GREEN and YELLOW phases are exact.
//  Error bookkeeping: err_pulse=1 for exactly one cycle. err_code is loaded with the code and err_count increments.
//  err_clr vs new error in the same cycle: the new error wins. err_code=new code, err_count=1.
//  err_count holds at 2^ERR_CNT_W-1. cycle_count wraps to 0 with no flag.
//  Reset asserted mid-phase: immediate return to reset values. Checking restarts from SYNC.
// STRUCTURE
//  Package traffic_light_pkg holds:
//   - light encodings LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001
//   - monitor_state_t enum {SYNC,RED,GREEN,YELLOW} with 2-bit encoding
//   - err_code constants ERR_NONE..ERR_LONG
//  Single module, no sub-module: state, dwell, clean flag and counters in one sequential block.
//  Next-state and check decode in one combinational block.
// TESTING
//  T1 Drive from traffic_light_controller with defaults, reset_n low 3 cycles, run 60 cycles.
//     Expected: cycle_count=4, err_count=0, phase follows GREEN(5)->YELLOW(3)->RED(5).
//  T2 In RED, force light=3'b010 -> err_code=2 SEQ, err_pulse for 1 cycle, phase=SYNC, err_count=1.
//  T3 GREEN held 4 cycles then YELLOW -> err_code=3 SHORT, phase=YELLOW, no cycle_done at the next RED.
//  T4 YELLOW held 4 cycles -> err_code=4 LONG on the 4th sample, phase=SYNC.
//  T5 light=3'b110 during GREEN -> ENC. Same cycle as err_clr=1: err_code=1, err_count=1.
//     Repeat errors 300 times -> err_count=255.
//  T6 Assert reset_n mid-YELLOW -> all outputs 0 immediately. Legal traffic after release resumes counting.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic light bus and its receive-side monitor.
package traffic_light_pkg;

  // One-hot light bus encodings: R=bit2, Y=bit1, G=bit0.
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Tracked phase; the encoding is also the value presented on the phase output.
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } monitor_state_t;

  // Error codes reported on err_code.
  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ENC   = 3'd1;
  localparam logic [2:0] ERR_SEQ   = 3'd2;
  localparam logic [2:0] ERR_SHORT = 3'd3;
  localparam logic [2:0] ERR_LONG  = 3'd4;

  // True when the sample is one of the three legal colours.
  function automatic logic is_one_hot(input logic [2:0] l);
    return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
  endfunction

  // Bus value expected while in a given phase; SYNC has no colour.
  function automatic logic [2:0] colour_of(input monitor_state_t s);
    case (s)
      RED:     return LIGHT_RED;
      GREEN:   return LIGHT_GREEN;
      YELLOW:  return LIGHT_YELLOW;
      default: return 3'b000;
    endcase
  endfunction

  // Phase that a legal colour sample belongs to; anything else maps to SYNC.
  function automatic monitor_state_t state_of(input logic [2:0] l);
    case (l)
      LIGHT_RED:    return RED;
      LIGHT_GREEN:  return GREEN;
      LIGHT_YELLOW: return YELLOW;
      default:      return SYNC;
    endcase
  endfunction

  // Legal successor phase: RED -> GREEN -> YELLOW -> RED.
  function automatic monitor_state_t next_state_of(input monitor_state_t s);
    case (s)
      RED:     return GREEN;
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      default: return SYNC;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the one-hot {R,Y,G} light bus: tracks the phase,
// checks order and exact dwell per phase, reports errors and counts cycles.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = 5,
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 3,
  parameter int ERR_CNT_W     = 8,
  parameter int CYC_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           light,
  input  logic                 err_clr,
  output logic [1:0]           phase,
  output logic                 err_pulse,
  output logic [2:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 cycle_done,
  output logic [CYC_CNT_W-1:0] cycle_count
);

  localparam int MAX_CYCLES =
    (RED_CYCLES > GREEN_CYCLES)
      ? ((RED_CYCLES > YELLOW_CYCLES) ? RED_CYCLES : YELLOW_CYCLES)
      : ((GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES);
  localparam int DWELL_W = $clog2(MAX_CYCLES + 2);

  localparam logic [DWELL_W-1:0]   RED_LIM    = DWELL_W'(RED_CYCLES);
  localparam logic [DWELL_W-1:0]   GREEN_LIM  = DWELL_W'(GREEN_CYCLES);
  localparam logic [DWELL_W-1:0]   YELLOW_LIM = DWELL_W'(YELLOW_CYCLES);
  localparam logic [DWELL_W-1:0]   DWELL_ONE  = DWELL_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE    = ERR_CNT_W'(1);
  localparam logic [CYC_CNT_W-1:0] CYC_ONE    = CYC_CNT_W'(1);

  // Registered state.
  monitor_state_t       state;
  logic [DWELL_W-1:0]   dwell;
  logic [2:0]           light_q;     // sample under check
  logic [2:0]           light_prev;  // sample before it, used to spot a change in SYNC
  logic                 sample_vld;  // light_q holds a real sample, not the reset value
  logic                 clean;       // current R-G-Y-R cycle has had no errors so far

  // Decoded next values.
  monitor_state_t       state_n;
  logic [DWELL_W-1:0]   dwell_n;
  logic                 clean_n;
  logic [2:0]           err_n;
  logic                 done_n;
  logic                 err_hit;

  monitor_state_t       succ;
  logic [2:0]           cur_col;
  logic [2:0]           succ_col;
  logic [DWELL_W-1:0]   lim;

  // Next-state and check decode for the sample currently in light_q.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_n  = state;
    dwell_n  = dwell;
    clean_n  = clean;
    err_n    = ERR_NONE;
    done_n   = 1'b0;
    succ     = next_state_of(state);
    cur_col  = colour_of(state);
    succ_col = colour_of(succ);
    case (state)
      RED:     lim = RED_LIM;
      GREEN:   lim = GREEN_LIM;
      YELLOW:  lim = YELLOW_LIM;
      default: lim = '0;
    endcase

    if (sample_vld) begin
      if (!is_one_hot(light_q)) begin
        err_n   = ERR_ENC;
        state_n = SYNC;
        dwell_n = '0;
        clean_n = 1'b0;
      end else if (state == SYNC) begin
        // Lock on the first legal colour change; durations are unknown here.
        if (is_one_hot(light_prev) &&
            (light_q == colour_of(next_state_of(state_of(light_prev))))) begin
          state_n = state_of(light_q);
          dwell_n = DWELL_ONE;
          clean_n = (state_of(light_q) == GREEN);
        end
      end else if ((light_q != cur_col) && (light_q != succ_col)) begin
        err_n   = ERR_SEQ;
        state_n = SYNC;
        dwell_n = '0;
        clean_n = 1'b0;
      end else if (light_q == succ_col) begin
        // Legal change: always follow it, flag it when the phase was cut short.
        state_n = succ;
        dwell_n = DWELL_ONE;
        if (dwell < lim) begin
          err_n   = ERR_SHORT;
          clean_n = 1'b0;
        end else begin
          if (state == RED) clean_n = 1'b1;
          if ((state == YELLOW) && clean) done_n = 1'b1;
        end
      end else if (dwell == lim) begin
        err_n   = ERR_LONG;
        state_n = SYNC;
        dwell_n = '0;
        clean_n = 1'b0;
      end else begin
        dwell_n = dwell + DWELL_ONE;
      end
    end
  end

  assign err_hit = (err_n != ERR_NONE);

  // State, sampling, strobes and counters.
  // NOTE: every register here, counters included, takes a defined value on reset; there is no memory array to leave unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC;
      dwell       <= '0;
      light_q     <= '0;
      light_prev  <= '0;
      sample_vld  <= 1'b0;
      clean       <= 1'b0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_NONE;
      err_count   <= '0;
      cycle_done  <= 1'b0;
      cycle_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
      light_q    <= light;
      light_prev <= light_q;
      sample_vld <= 1'b1;
      state      <= state_n;
      dwell      <= dwell_n;
      clean      <= clean_n;
      err_pulse  <= err_hit;
      cycle_done <= done_n;
      if (done_n) cycle_count <= cycle_count + CYC_ONE;
      // A new error takes precedence over a simultaneous clear.
      if (err_hit) begin
        err_code <= err_n;
        if (err_clr)                  err_count <= ERR_ONE;
        else if (err_count != ERR_MAX) err_count <= err_count + ERR_ONE;
      end else if (err_clr) begin
        err_code  <= ERR_NONE;
        err_count <= '0;
      end
    end
  end

  // Phase output is the tracked state encoding.
  always_comb begin
    phase = state;
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus
// randomized traffic, compared every cycle against a colour-index model.
module tb_traffic_light_monitor;

  logic        clk;
  logic        reset_n;
  logic [2:0]  light;
  logic        err_clr;
  logic [1:0]  phase;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [7:0]  err_count;
  logic        cycle_done;
  logic [15:0] cycle_count;

  traffic_light_monitor dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .light       (light),
    .err_clr     (err_clr),
    .phase       (phase),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .err_count   (err_count),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  int total = 0;
  int bad   = 0;

  // Reference model. Colours are indices in legal order: 0 red, 1 green, 2 yellow,
  // so the legal successor of colour c is (c+1)%3 and the phase output is c+1.
  int req [3] = '{5, 5, 3};
  int m_ph;        // -1 while unsynchronised
  int m_run;       // samples seen of the current colour
  int m_prev;      // colour index of the previous sample, -1 if none/illegal
  int m_lq;        // colour index of the sample waiting to be checked
  bit m_lq_ok;
  bit m_clean;
  bit e_pulse;
  bit e_done;
  int e_code;
  int e_count;
  int e_cyc;

  function automatic int idx_of(input logic [2:0] v);
    case (v)
      3'b100:  return 0;
      3'b001:  return 1;
      3'b010:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = -1; m_run = 0; m_prev = -1; m_lq = -1; m_lq_ok = 0; m_clean = 0;
    e_pulse = 0; e_done = 0; e_code = 0; e_count = 0; e_cyc = 0;
  endtask

  // One clock edge: judge the held sample, then take v as the new one.
  task automatic model_step(input logic [2:0] v, input bit clr);
    int i;
    int err;
    bit done;
    err = 0; done = 0; i = m_lq;
    if (m_lq_ok) begin
      if (i < 0) begin
        err = 1; m_ph = -1; m_clean = 0;
      end else if (m_ph < 0) begin
        if (m_prev >= 0 && i == (m_prev + 1) % 3) begin
          m_ph = i; m_run = 1; m_clean = (i == 1);
        end
      end else if (i != m_ph && i != (m_ph + 1) % 3) begin
        err = 2; m_ph = -1; m_clean = 0;
      end else if (i != m_ph) begin
        if (m_run < req[m_ph]) begin
          err = 3; m_clean = 0;
        end else begin
          if (m_ph == 2 && m_clean) done = 1;
          if (m_ph == 0) m_clean = 1;
        end
        m_ph = i; m_run = 1;
      end else if (m_run == req[m_ph]) begin
        err = 4; m_ph = -1; m_clean = 0;
      end else begin
        m_run++;
      end
    end
    m_prev  = i;
    m_lq    = idx_of(v);
    m_lq_ok = 1;
    e_pulse = (err != 0);
    e_done  = done;
    if (err != 0) begin
      e_code  = err;
      e_count = clr ? 1 : ((e_count < 255) ? e_count + 1 : 255);
    end else if (clr) begin
      e_code  = 0;
      e_count = 0;
    end
    if (done) e_cyc = (e_cyc + 1) % 65536;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".phase"},       32'(phase),       32'((m_ph < 0) ? 0 : m_ph + 1));
    check({tag, ".err_pulse"},   32'(err_pulse),   32'(e_pulse));
    check({tag, ".err_code"},    32'(err_code),    32'(e_code));
    check({tag, ".err_count"},   32'(err_count),   32'(e_count));
    check({tag, ".cycle_done"},  32'(cycle_done),  32'(e_done));
    check({tag, ".cycle_count"}, 32'(cycle_count), 32'(e_cyc));
  endtask

  // Drive one sample at the falling edge, clock it, compare at the next falling edge.
  task automatic tick(input logic [2:0] v, input bit clr);
    light   = v;
    err_clr = clr;
    @(posedge clk);
    model_step(v, clr);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic drive(input logic [2:0] v, input int n);
    for (int k = 0; k < n; k++) tick(v, 1'b0);
  endtask

  logic [2:0] col [3] = '{R, G, Y};

  initial begin
    reset_n = 1'b0;
    light   = 3'b000;
    err_clr = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // T1: legal traffic, four complete cycles after locking on.
    drive(R, 5);
    for (int c = 0; c < 4; c++) begin
      drive(G, 5); drive(Y, 3); drive(R, 5);
    end
    check("t1.cycle_count", 32'(cycle_count), 32'd4);
    check("t1.err_count",   32'(err_count),   32'd0);

    // T2: yellow while in RED is a sequence error.
    drive(G, 5); drive(Y, 3); drive(R, 2); drive(Y, 1);
    tick(Y, 1'b0);
    check("t2.err_pulse", 32'(err_pulse), 32'd1);
    check("t2.err_code",  32'(err_code),  32'd2);
    check("t2.phase",     32'(phase),     32'd0);
    check("t2.err_count", 32'(err_count), 32'd1);
    tick(Y, 1'b0);
    check("t2.pulse_once", 32'(err_pulse), 32'd0);

    // T3: short green, then no cycle credit at the following red.
    drive(R, 5); drive(G, 4); drive(Y, 1);
    tick(Y, 1'b0);
    check("t3.err_code", 32'(err_code), 32'd3);
    check("t3.phase",    32'(phase),    32'd3);
    drive(Y, 1); drive(R, 1);
    tick(R, 1'b0);
    check("t3.no_done", 32'(cycle_done), 32'd0);
    check("t3.phase_r", 32'(phase),      32'd1);
    drive(R, 3);

    // T4: yellow held one sample too long.
    drive(G, 5); drive(Y, 4);
    tick(R, 1'b0);
    check("t4.err_code", 32'(err_code), 32'd4);
    check("t4.phase",    32'(phase),    32'd0);

    // T5: illegal encoding during GREEN coinciding with a clear, then saturation.
    drive(R, 4); drive(G, 2);
    tick(3'b110, 1'b0);
    tick(G, 1'b1);
    check("t5.err_code",  32'(err_code),  32'd1);
    check("t5.err_count", 32'(err_count), 32'd1);
    for (int k = 0; k < 300; k++) tick(3'b111, 1'b0);
    tick(R, 1'b0);
    check("t5.saturate", 32'(err_count), 32'd255);

    // Randomized traffic: mostly exact phases, some off-by-one, rare glitches and clears.
    for (int p = 0; p < 45; p++) begin
      int c;
      int n;
      int r;
      c = p % 3;
      n = req[c];
      r = $urandom_range(0, 9);
      if (r == 0) n = n - 1;
      else if (r == 1) n = n + 1;
      for (int k = 0; k < n; k++) begin
        logic [2:0] v;
        v = col[c];
        if ($urandom_range(0, 29) == 0) v = 3'($urandom_range(0, 7));
        tick(v, ($urandom_range(0, 15) == 0));
      end
    end

    // T6: reset asserted in the middle of YELLOW, then legal traffic resumes counting.
    drive(Y, 1); drive(R, 5); drive(G, 5); drive(Y, 2);
    check("t6.in_yellow", 32'(phase), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(R, 5);
    for (int c = 0; c < 2; c++) begin
      drive(G, 5); drive(Y, 3); drive(R, 5);
    end
    check("t6.cycle_count", 32'(cycle_count), 32'd2);
    check("t6.err_count",   32'(err_count),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
